// File: rtl/spi_master_if.sv
// SPI master host-side and pin-side signal bundle.
// Pure wiring; no state and no added latency.
// No backpressure: start is sampled by the master only while it is idle.
interface spi_master_if;
    // host side
    logic       start;
    logic [7:0] tdata;
    logic       mlb;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    // SPI pins
    logic       ss;
    logic       sck;
    logic       sdout;
    logic       sdin;

    modport master (
        input  start, tdata, mlb, sdin,
        output busy, done, rdata, ss, sck, sdout
    );

    modport slave (
        output start, tdata, mlb, sdin,
        input  busy, done, rdata, ss, sck, sdout
    );
endinterface

// File: rtl/spi_master.sv
// Mode-3 SPI master: one 8-bit full-duplex frame per accepted start, MSB- or LSB-first.
// Latency: ss low one cycle after start; done pulses 1+17*HALF_DIV cycles after start is sampled.
// Backpressure: start is only honoured in IDLE; requests while busy are dropped, not queued.
module spi_master #(
    parameter int unsigned HALF_DIV = 4   // SCK half-period in clk cycles, 1..255
) (
    input  logic         clk,
    input  logic         rstb,
    spi_master_if.master bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEAD  = 3'd1,
        LOW   = 3'd2,
        HIGH  = 3'd3,
        TRAIL = 3'd4,
        GAP   = 3'd5
    } state_t;

    localparam logic [7:0] CNT_LOAD = 8'(HALF_DIV - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q,   cnt_d;     // phase down-counter
    logic [2:0] bit_q,   bit_d;     // index of the bit currently on the wire
    logic [7:0] tx_q,    tx_d;      // transmit shift register
    logic [7:0] rx_q,    rx_d;      // receive shift register
    logic       mlb_q,   mlb_d;     // bit order captured with start
    logic       ss_q,    ss_d;
    logic       sck_q,   sck_d;
    logic       sdout_q, sdout_d;
    logic       busy_q,  busy_d;
    logic       done_q,  done_d;
    logic [7:0] rdata_q, rdata_d;

    logic       phase_end;

    assign phase_end = (cnt_q == 8'd0);

    // State and datapath registers; reset forces the idle bus pattern immediately.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            bit_q   <= 3'd0;
            tx_q    <= 8'd0;
            rx_q    <= 8'd0;
            mlb_q   <= 1'b0;
            ss_q    <= 1'b1;
            sck_q   <= 1'b1;
            sdout_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            mlb_q   <= mlb_d;
            ss_q    <= ss_d;
            sck_q   <= sck_d;
            sdout_q <= sdout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state: each phase lasts HALF_DIV cycles; the last bit's high half is TRAIL,
    // so the frame is LEAD + 16 half-periods and ss rises 17 half-periods after it fell.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        if (state_q == IDLE) begin
            if (bus.start) begin
                state_d = LEAD;
                cnt_d   = CNT_LOAD;
                bit_d   = 3'd0;
            end
        end else if (!phase_end) begin
            cnt_d = cnt_q - 8'd1;
        end else begin
            cnt_d = CNT_LOAD;
            case (state_q)
                LEAD:    state_d = LOW;
                LOW:     state_d = (bit_q == 3'd7) ? TRAIL : HIGH;
                HIGH: begin
                    state_d = LOW;
                    bit_d   = bit_q + 3'd1;
                end
                TRAIL:   state_d = GAP;
                GAP:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs and shift registers, updated on the phase boundaries that the FSM takes.
    always_comb begin
        tx_d    = tx_q;
        rx_d    = rx_q;
        mlb_d   = mlb_q;
        ss_d    = ss_q;
        sck_d   = sck_q;
        sdout_d = sdout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    tx_d    = bus.tdata;
                    mlb_d   = bus.mlb;
                    rx_d    = 8'd0;
                    ss_d    = 1'b0;
                    sck_d   = 1'b1;
                    sdout_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            LEAD, HIGH: begin
                // falling sck edge: present the next tx bit for the whole low+high period
                if (phase_end) begin
                    sck_d = 1'b0;
                    if (mlb_q) begin
                        sdout_d = tx_q[7];
                        tx_d    = {tx_q[6:0], 1'b0};
                    end else begin
                        sdout_d = tx_q[0];
                        tx_d    = {1'b0, tx_q[7:1]};
                    end
                end
            end
            LOW: begin
                // rising sck edge: sample sdin on the same clk edge
                if (phase_end) begin
                    sck_d = 1'b1;
                    if (mlb_q) begin
                        rx_d = {rx_q[6:0], bus.sdin};
                    end else begin
                        rx_d = {bus.sdin, rx_q[7:1]};
                    end
                end
            end
            TRAIL: begin
                if (phase_end) begin
                    ss_d    = 1'b1;
                    sdout_d = 1'b0;
                    done_d  = 1'b1;
                    rdata_d = rx_q;
                end
            end
            GAP: begin
                if (phase_end) begin
                    busy_d = 1'b0;
                end
            end
            default: begin
                ss_d    = 1'b1;
                sck_d   = 1'b1;
                sdout_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.ss    = ss_q;
    assign bus.sck   = sck_q;
    assign bus.sdout = sdout_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.rdata = rdata_q;

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter: HALF_DIV, 4, SCK half-period in clk cycles; legal range 1..255.
REQ-002 SHALL have port: clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port: rstb  input  1  one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port: start  input  1  transfer request, sampled in IDLE only.
REQ-005 SHALL have port: tdata  input  8  byte to transmit, captured with start.
REQ-006 SHALL have port: mlb  input  1  bit order, 1 = MSB first, 0 = LSB first; captured with start.
REQ-007 SHALL have port: ss  output  1  slave select, active-low.
REQ-008 SHALL have port: sck  output  1  serial clock, idles high.
REQ-009 SHALL have port: sdout  output  1  master-out serial data.
REQ-010 SHALL have port: sdin  input  1  master-in serial data.
REQ-011 SHALL have port: busy  output  1  high from accepted start until return to IDLE.
REQ-012 SHALL have port: done  output  1  one-cycle pulse at frame end.
REQ-013 SHALL have port: rdata  output  8  last received byte, held until next done.

Function
REQ-014 SHALL implement the states IDLE, LEAD, LOW, HIGH, TRAIL and GAP, with one down-counter loaded with HALF_DIV-1 per phase and a 3-bit bit counter.
REQ-015 SHALL, in IDLE with start=1, capture tdata and mlb, drive ss=0 on the next cycle (cycle 1), set busy=1, and enter LEAD.
REQ-016 SHALL hold LEAD for HALF_DIV cycles with sck=1, then enter LOW.
REQ-017 SHALL, on entering LOW, drive sck=0 and update sdout to the next tx bit (tdata[7] down to tdata[0] if mlb=1, tdata[0] up if mlb=0); sdout SHALL be stable for the whole bit.
REQ-018 SHALL hold LOW for HALF_DIV cycles, then drive sck=1, register sdin on that same clk edge into the rx shift register, and enter HIGH.
REQ-019 SHALL assemble rx bits so that the first bit received lands in bit 7 if mlb=1 and in bit 0 if mlb=0.
REQ-020 SHALL hold HIGH for HALF_DIV cycles, then go to LOW for the next bit, or to TRAIL after the 8th bit; it SHALL generate exactly 8 sck falling edges per frame.
REQ-021 SHALL hold TRAIL for HALF_DIV cycles with ss=0 and sck=1, then drive ss=1, load rdata, pulse done for one cycle, and enter GAP.
REQ-022 SHALL set frame timing as follows: first sck fall at cycle 1+H, last sck rise at cycle 1+16H, ss rising and done at cycle 1+17H (H = HALF_DIV).
REQ-023 SHALL hold GAP for HALF_DIV cycles with ss=1 and busy=1, then enter IDLE, giving a minimum ss-high time of HALF_DIV cycles between frames.
REQ-024 SHALL ignore start when not in IDLE, without queueing it; if start is held high continuously, a new frame begins on the first IDLE cycle.
REQ-025 SHALL drive sdout=0 whenever ss=1.
REQ-026 SHALL not allow changes to tdata or mlb after capture to affect the frame in flight.

Reset
REQ-027 SHALL, while rstb=0 and regardless of clk, force state IDLE, ss=1, sck=1, sdout=0, busy=0, done=0, rdata=0x00, and clear all counters and shift registers.
REQ-028 SHALL abort a transfer in progress when reset occurs mid-frame, with no done pulse and rdata=0x00; the first start after rstb rises SHALL run a complete, correct frame.

Verification
REQ-029 SHALL verify reset: assert rstb=0 at any time -> ss=1, sck=1, sdout=0, busy=0, done=0, rdata=0x00 with no clk edge required.
REQ-030 SHALL verify MSB-first loopback: HALF_DIV=4, sdin tied to sdout, tdata=0x7C, mlb=1, one-cycle start -> sdout bits 0,1,1,1,1,1,0,0, 8 sck falls, done at cycle 69, rdata=0x7C.
REQ-031 SHALL verify LSB-first against a mode-3 slave model: slave model returns 0xA5 LSB-first, tdata=0x70, mlb=0 -> sdout bits 0,0,0,0,1,1,1,0 and rdata=0xA5.
REQ-032 SHALL verify start during busy: pulse start at bit 3 of a frame -> no extra sck edges, single done pulse, busy low after GAP.
REQ-033 SHALL verify mid-frame reset: rstb=0 during bit 4 -> ss=1 and sck=1 immediately, no done; then start with 0x3C in loopback -> rdata=0x3C.
REQ-034 SHALL verify back-to-back frames: start held high, HALF_DIV=1 -> two consecutive frames with ss high for at least 1 cycle between them, and a done pulse for each.
